// File: rtl/logo_pkg.sv
// Shared constants and types for the bouncing logo sprite renderer.
// Imported by the renderer top level and its bounce controller.
package logo_pkg;

  localparam int H_RES          = 640;
  localparam int V_RES          = 480;
  localparam int LOGO_W         = 128;
  localparam int LOGO_H         = 28;
  localparam int BYTES_PER_LINE = 16;
  localparam int LOGO_ADDR_W    = 9;
  localparam int RGB_W          = 12;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  typedef struct packed {
    logic       valid;
    logic       hit;
    logic [2:0] sel;
  } pix_t;

endpackage

// File: rtl/logo_bounce.sv
// Screensaver-style position controller for the logo.
// Moves one step per enabled frame and reflects off the screen walls.
module logo_bounce
  import logo_pkg::*;
#(
  parameter int H_RES  = logo_pkg::H_RES,
  parameter int V_RES  = logo_pkg::V_RES,
  parameter int LOGO_W = logo_pkg::LOGO_W,
  parameter int LOGO_H = logo_pkg::LOGO_H,
  parameter int STEP   = 1,
  parameter int INIT_X = 256,
  parameter int INIT_Y = 226
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       move_en,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       bounce_pulse
);

  localparam logic [10:0] X_MAX = 11'(H_RES - LOGO_W);
  localparam logic [10:0] Y_MAX = 11'(V_RES - LOGO_H);
  localparam logic [10:0] STP11 = 11'(STEP);
  localparam logic [9:0]  STP10 = 10'(STEP);

  dir_e       dir_x, dir_y;
  dir_e       dir_x_nxt, dir_y_nxt;
  logic [9:0] x_nxt, y_nxt;
  logic       hit_x, hit_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x        <= 10'(INIT_X);
      pos_y        <= 10'(INIT_Y);
      dir_x        <= DIR_POS;
      dir_y        <= DIR_POS;
      bounce_pulse <= 1'b0;
    end else begin
      pos_x        <= x_nxt;
      pos_y        <= y_nxt;
      dir_x        <= dir_x_nxt;
      dir_y        <= dir_y_nxt;
      bounce_pulse <= hit_x | hit_y;
    end
  end

  // Sums are widened to 11 bits so pos+STEP never wraps.
  always_comb begin
    x_nxt     = pos_x;
    y_nxt     = pos_y;
    dir_x_nxt = dir_x;
    dir_y_nxt = dir_y;
    hit_x     = 1'b0;
    hit_y     = 1'b0;
    if (frame_start && move_en) begin
      unique case (dir_x)
        DIR_POS: begin
          if ({1'b0, pos_x} + STP11 >= X_MAX) begin
            x_nxt     = X_MAX[9:0];
            dir_x_nxt = DIR_NEG;
            hit_x     = 1'b1;
          end else begin
            x_nxt = pos_x + STP10;
          end
        end
        DIR_NEG: begin
          if ({1'b0, pos_x} <= STP11) begin
            x_nxt     = '0;
            dir_x_nxt = DIR_POS;
            hit_x     = 1'b1;
          end else begin
            x_nxt = pos_x - STP10;
          end
        end
      endcase
      unique case (dir_y)
        DIR_POS: begin
          if ({1'b0, pos_y} + STP11 >= Y_MAX) begin
            y_nxt     = Y_MAX[9:0];
            dir_y_nxt = DIR_NEG;
            hit_y     = 1'b1;
          end else begin
            y_nxt = pos_y + STP10;
          end
        end
        DIR_NEG: begin
          if ({1'b0, pos_y} <= STP11) begin
            y_nxt     = '0;
            dir_y_nxt = DIR_POS;
            hit_y     = 1'b1;
          end else begin
            y_nxt = pos_y - STP10;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/logo_sprite_renderer.sv
// Logo sprite renderer: VGA counters -> ROM address -> per-pixel colour.
// The ROM answers one full clock after the address, hence two stages.
module logo_sprite_renderer
  import logo_pkg::*;
#(
  parameter int H_RES  = logo_pkg::H_RES,
  parameter int V_RES  = logo_pkg::V_RES,
  parameter int LOGO_W = logo_pkg::LOGO_W,
  parameter int LOGO_H = logo_pkg::LOGO_H,
  parameter int STEP   = 1,
  parameter int INIT_X = 256,
  parameter int INIT_Y = 226,
  parameter logic [RGB_W-1:0] FG_COLOR = 12'hFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_tick,
  input  logic [9:0]             hcount,
  input  logic [9:0]             vcount,
  input  logic                   video_on,
  input  logic                   frame_start,
  input  logic                   move_en,
  output logic [LOGO_ADDR_W-1:0] rom_addr,
  input  logic [7:0]             rom_data,
  output logic                   logo_on,
  output logic [RGB_W-1:0]       logo_rgb,
  output logic [9:0]             pos_x,
  output logic [9:0]             pos_y,
  output logic                   bounce_pulse
);

  logic [10:0] h11, v11, px11, py11;
  logic        hit;
  logic [6:0]  rel_x;
  logic [4:0]  rel_y;
  logic        px_on;
  pix_t        s1, s2;

  assign h11  = {1'b0, hcount};
  assign v11  = {1'b0, vcount};
  assign px11 = {1'b0, pos_x};
  assign py11 = {1'b0, pos_y};

  assign hit = video_on
             && (h11 >= px11) && (h11 < px11 + 11'(LOGO_W))
             && (v11 >= py11) && (v11 < py11 + 11'(LOGO_H));

  // Only the low bits of the offsets are needed once hit holds.
  assign rel_x = hcount[6:0] - pos_x[6:0];
  assign rel_y = vcount[4:0] - pos_y[4:0];
  assign px_on = s2.hit & rom_data[s2.sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      s1       <= '0;
      s2       <= '0;
      logo_on  <= 1'b0;
      logo_rgb <= '0;
    end else begin
      s1.valid <= pix_tick;
      if (pix_tick) begin
        rom_addr <= hit ? {rel_y, rel_x[6:3]} : '0;
        s1.hit   <= hit;
        s1.sel   <= 3'd7 - rel_x[2:0];
      end
      s2 <= s1;
      if (s2.valid) begin
        logo_on  <= px_on;
        logo_rgb <= px_on ? FG_COLOR : '0;
      end
    end
  end

  logo_bounce #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .LOGO_W(LOGO_W),
    .LOGO_H(LOGO_H),
    .STEP  (STEP),
    .INIT_X(INIT_X),
    .INIT_Y(INIT_Y)
  ) u_bounce (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .move_en     (move_en),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .bounce_pulse(bounce_pulse)
  );

endmodule

// File: tb/tb_logo_sprite_renderer.sv
// Bench for logo_sprite_renderer: reference model of pixels and motion.
// A second instance starts near the corner to exercise a double bounce.
module tb_logo_sprite_renderer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, pix_tick, video_on, frame_start, move_en;
  logic [9:0] hcount, vcount;
  logic [8:0] rom_addr;
  logic [7:0] rom_data;
  logic       logo_on;
  logic [11:0] logo_rgb;
  logic [9:0] pos_x, pos_y;
  logic       bounce_pulse;

  logic [8:0]  c_rom_addr;
  logic        c_logo_on;
  logic [11:0] c_logo_rgb;
  logic [9:0]  c_pos_x, c_pos_y;
  logic        c_pulse;

  logo_sprite_renderer dut (
    .clk(clk), .rst(rst), .pix_tick(pix_tick),
    .hcount(hcount), .vcount(vcount), .video_on(video_on),
    .frame_start(frame_start), .move_en(move_en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .logo_on(logo_on), .logo_rgb(logo_rgb),
    .pos_x(pos_x), .pos_y(pos_y), .bounce_pulse(bounce_pulse)
  );

  logo_sprite_renderer #(.INIT_X(511), .INIT_Y(451)) dut_c (
    .clk(clk), .rst(rst), .pix_tick(pix_tick),
    .hcount(hcount), .vcount(vcount), .video_on(video_on),
    .frame_start(frame_start), .move_en(move_en),
    .rom_addr(c_rom_addr), .rom_data(8'h00),
    .logo_on(c_logo_on), .logo_rgb(c_logo_rgb),
    .pos_x(c_pos_x), .pos_y(c_pos_y), .bounce_pulse(c_pulse)
  );

  // ROM: captures the address on negedge, data follows a negedge later.
  logic [7:0] mem [512];
  logic [8:0] rom_aq;
  always @(negedge clk) begin
    rom_aq   <= rom_addr;
    rom_data <= mem[rom_aq];
  end

  int n_cmp = 0;
  int n_bad = 0;

  int          m_x, m_y, m_dx, m_dy;
  logic        exp_pulse, exp_on;
  logic [8:0]  exp_addr;
  logic        pend_t [2];
  logic        pend_o [2];

  function automatic void model_reset();
    m_x = 256; m_y = 226; m_dx = 1; m_dy = 1;
    exp_pulse = 1'b0; exp_on = 1'b0; exp_addr = '0;
    pend_t[0] = 1'b0; pend_t[1] = 1'b0;
    pend_o[0] = 1'b0; pend_o[1] = 1'b0;
  endfunction

  function automatic void ref_pixel(input int h, input int v,
      input logic von, input int px, input int py,
      output logic hit, output logic [8:0] addr, output logic on);
    int rx, ry;
    logic [7:0] b;
    rx = h - px;
    ry = v - py;
    hit = von && h >= px && h < px + 128 && v >= py && v < py + 28;
    addr = hit ? 9'(ry * 16 + rx / 8) : 9'd0;
    b = mem[addr];
    on = hit ? b[7 - rx % 8] : 1'b0;
  endfunction

  function automatic void axis(inout int p, inout int d,
      input int lim, output logic hit);
    hit = 1'b0;
    if (d > 0) begin
      if (p + 1 >= lim) begin p = lim; d = -1; hit = 1'b1; end
      else p = p + 1;
    end else begin
      if (p <= 1) begin p = 0; d = 1; hit = 1'b1; end
      else p = p - 1;
    end
  endfunction

  // Drive one clock of inputs and advance the reference model.
  task automatic step(input logic r, input logic t, input int h,
      input int v, input logic von, input logic fs, input logic me);
    logic hit, on, hx, hy;
    logic [8:0] a;
    rst = r; pix_tick = t; hcount = 10'(h); vcount = 10'(v);
    video_on = von; frame_start = fs; move_en = me;
    ref_pixel(h, v, von, m_x, m_y, hit, a, on);
    @(negedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (pend_t[1]) exp_on = pend_o[1];
      pend_t[1] = pend_t[0]; pend_o[1] = pend_o[0];
      pend_t[0] = t;         pend_o[0] = on;
      if (t) exp_addr = a;
      exp_pulse = 1'b0;
      if (fs && me) begin
        axis(m_x, m_dx, 512, hx);
        axis(m_y, m_dy, 452, hy);
        exp_pulse = hx | hy;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
    n_cmp += 5;
    if (pos_x !== 10'd256) begin n_bad++; $display("FAIL reset pos_x got %0d want 256", pos_x); end
    if (pos_y !== 10'd226) begin n_bad++; $display("FAIL reset pos_y got %0d want 226", pos_y); end
    if (logo_on !== 1'b0) begin n_bad++; $display("FAIL reset logo_on got %b want 0", logo_on); end
    if (rom_addr !== 9'd0) begin n_bad++; $display("FAIL reset rom_addr got %h want 0", rom_addr); end
    if (bounce_pulse !== 1'b0) begin n_bad++; $display("FAIL reset bounce got %b want 0", bounce_pulse); end
  endtask

  task automatic test_corner();
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    n_cmp += 3;
    if (c_pos_x !== 10'd512) begin n_bad++; $display("FAIL corner x got %0d want 512", c_pos_x); end
    if (c_pos_y !== 10'd452) begin n_bad++; $display("FAIL corner y got %0d want 452", c_pos_y); end
    if (c_pulse !== 1'b1) begin n_bad++; $display("FAIL corner pulse got %b want 1", c_pulse); end
    idle(1);
    n_cmp++;
    if (c_pulse !== 1'b0) begin n_bad++; $display("FAIL corner pulse2 got %b want 0", c_pulse); end
    step(0, 0, 0, 0, 0, 1, 1);
    n_cmp += 3;
    if (c_pos_x !== 10'd511) begin n_bad++; $display("FAIL corner back x got %0d want 511", c_pos_x); end
    if (c_pos_y !== 10'd451) begin n_bad++; $display("FAIL corner back y got %0d want 451", c_pos_y); end
    if (c_pulse !== 1'b0) begin n_bad++; $display("FAIL corner back pulse got %b want 0", c_pulse); end
  endtask

  task automatic test_addressing();
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 259, 231, 1, 0, 0);
    n_cmp += 2;
    if (rom_addr !== 9'h050) begin n_bad++; $display("FAIL addr got %h want 050", rom_addr); end
    if (rom_addr !== exp_addr) begin n_bad++; $display("FAIL addr model got %h want %h", rom_addr, exp_addr); end
    idle(1);
    n_cmp++;
    if (logo_on !== 1'b0) begin n_bad++; $display("FAIL addr early on got %b want 0", logo_on); end
    idle(1);
    n_cmp += 3;
    if (logo_on !== 1'b1) begin n_bad++; $display("FAIL addr on got %b want 1", logo_on); end
    if (logo_rgb !== 12'hFFF) begin n_bad++; $display("FAIL addr rgb got %h want FFF", logo_rgb); end
    if (logo_on !== exp_on) begin n_bad++; $display("FAIL addr model on got %b want %b", logo_on, exp_on); end
    step(0, 1, 256, 231, 1, 0, 0);
    idle(2);
    n_cmp += 2;
    if (logo_on !== 1'b0) begin n_bad++; $display("FAIL addr bit7 on got %b want 0", logo_on); end
    if (logo_rgb !== 12'h000) begin n_bad++; $display("FAIL addr bit7 rgb got %h want 000", logo_rgb); end
  endtask

  task automatic test_edges();
    int hs [3] = '{255, 384, 300};
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 259, 231, 1, 0, 0);
      step(0, 1, hs[k], 231, k != 2, 0, 0);
      n_cmp++;
      if (rom_addr !== 9'd0) begin n_bad++; $display("FAIL edge%0d addr got %h want 0", k, rom_addr); end
      idle(1);
      n_cmp++;
      if (logo_on !== 1'b1) begin n_bad++; $display("FAIL edge%0d prev on got %b want 1", k, logo_on); end
      idle(1);
      n_cmp++;
      if (logo_on !== 1'b0) begin n_bad++; $display("FAIL edge%0d on got %b want 0", k, logo_on); end
    end
  endtask

  task automatic test_back_to_back();
    int v;
    v = 226 + $urandom_range(0, 27);
    for (int h = 250; h < 392; h++) begin
      step(0, 1, h, v, 1, 0, 0);
      n_cmp += 3;
      if (logo_on !== exp_on) begin n_bad++; $display("FAIL b2b h=%0d on got %b want %b", h, logo_on, exp_on); end
      if (logo_rgb !== (exp_on ? 12'hFFF : 12'h000)) begin n_bad++; $display("FAIL b2b h=%0d rgb got %h", h, logo_rgb); end
      if (rom_addr !== exp_addr) begin n_bad++; $display("FAIL b2b h=%0d addr got %h want %h", h, rom_addr, exp_addr); end
    end
    idle(2);
    n_cmp++;
    if (logo_on !== exp_on) begin n_bad++; $display("FAIL b2b tail on got %b want %b", logo_on, exp_on); end
  endtask

  task automatic test_right_bounce();
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 255; i++) begin
      step(0, 0, 0, 0, 0, 1, 1);
      n_cmp += 3;
      if (pos_x !== 10'(m_x)) begin n_bad++; $display("FAIL walk x got %0d want %0d", pos_x, m_x); end
      if (pos_y !== 10'(m_y)) begin n_bad++; $display("FAIL walk y got %0d want %0d", pos_y, m_y); end
      if (bounce_pulse !== exp_pulse) begin n_bad++; $display("FAIL walk pulse got %b want %b", bounce_pulse, exp_pulse); end
      idle(1);
    end
    n_cmp++;
    if (pos_x !== 10'd511) begin n_bad++; $display("FAIL right pre x got %0d want 511", pos_x); end
    step(0, 0, 0, 0, 0, 1, 1);
    n_cmp += 2;
    if (pos_x !== 10'd512) begin n_bad++; $display("FAIL right x got %0d want 512", pos_x); end
    if (bounce_pulse !== 1'b1) begin n_bad++; $display("FAIL right pulse got %b want 1", bounce_pulse); end
    idle(1);
    n_cmp++;
    if (bounce_pulse !== 1'b0) begin n_bad++; $display("FAIL right pulse2 got %b want 0", bounce_pulse); end
    step(0, 0, 0, 0, 0, 1, 1);
    n_cmp++;
    if (pos_x !== 10'd511) begin n_bad++; $display("FAIL right back x got %0d want 511", pos_x); end
  endtask

  task automatic test_hold_and_reset();
    logic [9:0] hx, hy;
    hx = pos_x; hy = pos_y;
    step(0, 0, 0, 0, 0, 1, 0);
    n_cmp += 3;
    if (pos_x !== hx) begin n_bad++; $display("FAIL hold x got %0d want %0d", pos_x, hx); end
    if (pos_y !== hy) begin n_bad++; $display("FAIL hold y got %0d want %0d", pos_y, hy); end
    if (bounce_pulse !== 1'b0) begin n_bad++; $display("FAIL hold pulse got %b want 0", bounce_pulse); end
    step(0, 1, m_x, m_y, 1, 0, 0);
    idle(2);
    step(0, 1, m_x + 3, m_y + 5, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (logo_on !== 1'b0) begin n_bad++; $display("FAIL rst drop on got %b want 0", logo_on); end
    end
    n_cmp += 2;
    if (pos_x !== 10'd256) begin n_bad++; $display("FAIL rst x got %0d want 256", pos_x); end
    if (pos_y !== 10'd226) begin n_bad++; $display("FAIL rst y got %0d want 226", pos_y); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++) begin
      step(0, $urandom_range(0, 3) != 0,
           m_x + $urandom_range(0, 140) - 6,
           m_y + $urandom_range(0, 34) - 3,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) != 0);
      n_cmp += 5;
      if (logo_on !== exp_on) begin n_bad++; $display("FAIL rnd%0d on got %b want %b", i, logo_on, exp_on); end
      if (logo_rgb !== (exp_on ? 12'hFFF : 12'h000)) begin n_bad++; $display("FAIL rnd%0d rgb got %h", i, logo_rgb); end
      if (rom_addr !== exp_addr) begin n_bad++; $display("FAIL rnd%0d addr got %h want %h", i, rom_addr, exp_addr); end
      if ({pos_x, pos_y} !== {10'(m_x), 10'(m_y)}) begin n_bad++; $display("FAIL rnd%0d pos got %0d,%0d want %0d,%0d", i, pos_x, pos_y, m_x, m_y); end
      if (bounce_pulse !== exp_pulse) begin n_bad++; $display("FAIL rnd%0d pulse got %b want %b", i, bounce_pulse, exp_pulse); end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    mem[9'h050] = 8'h18;
    rst = 1'b1; pix_tick = 1'b0; hcount = '0; vcount = '0;
    video_on = 1'b0; frame_start = 1'b0; move_en = 1'b0;
    model_reset();
    test_reset();
    test_corner();
    test_addressing();
    test_edges();
    test_back_to_back();
    test_right_bounce();
    test_hold_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
